// File: rtl/machine_trap_controller.sv
`default_nettype none
// ============================================================================
// machine_trap_controller : M-mode trap entry/return sequencer, cause latch
// Revision 1.0
// ============================================================================
module machine_trap_controller #(
  parameter int NUM_IRQ        = 3,
  parameter int CAUSE_W        = 5,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter int BOOT_CYCLES    = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               illegal_instr_in,
  input  logic               misaligned_instr_in,
  input  logic               misaligned_load_in,
  input  logic               misaligned_store_in,
  input  logic [4:0]         opcode_6_to_2_in,
  input  logic [2:0]         funct3_in,
  input  logic [6:0]         funct7_in,
  input  logic [4:0]         rs1_adder_in,
  input  logic [4:0]         rs2_adder_in,
  input  logic [4:0]         rd_adder_in,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en_in,
  input  logic               mie_in,
  output logic [1:0]         pc_src_out,
  output logic               flush_out,
  output logic               instruct_inc_out,
  output logic               set_epc_out,
  output logic               set_cause_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic               trap_taken_out,
  output logic               i_or_e_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               misaligned_exception_out
);

  localparam int CNT_W = $clog2(BOOT_CYCLES + 1);

  localparam logic [CAUSE_W-1:0] CAUSE_MIS_INSTR = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL   = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] CAUSE_EBREAK    = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] CAUSE_MIS_LOAD  = CAUSE_W'(4);
  localparam logic [CAUSE_W-1:0] CAUSE_MIS_STORE = CAUSE_W'(6);
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL     = CAUSE_W'(11);

  typedef enum logic [1:0] {
    ST_RESET       = 2'd0,
    ST_OPERATING   = 2'd1,
    ST_TRAP_TAKEN  = 2'd2,
    ST_TRAP_RETURN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               i_or_e_q, i_or_e_d;
  logic               misaligned_q;

  logic               is_system;
  logic               is_ecall;
  logic               is_ebreak;
  logic               is_mret;
  logic [NUM_IRQ-1:0] irq_pend;
  logic               irq_req;
  logic               trap_req;
  logic [CAUSE_W-1:0] irq_cause;
  logic [CAUSE_W-1:0] trap_cause;

  assign is_system = (opcode_6_to_2_in == 5'b11100) && (rs1_adder_in == 5'd0) &&
                     (rd_adder_in == 5'd0) && (funct3_in == 3'd0);
  assign is_ecall  = is_system && (rs2_adder_in == 5'd0) && (funct7_in == 7'd0);
  assign is_ebreak = is_system && (rs2_adder_in == 5'd1) && (funct7_in == 7'd0);
  assign is_mret   = is_system && (rs2_adder_in == 5'd2) && (funct7_in == 7'b0011000);

  assign irq_pend = irq_in & irq_en_in;
  assign irq_req  = mie_in && (|irq_pend);
  assign trap_req = irq_req || illegal_instr_in || misaligned_instr_in ||
                    misaligned_load_in || misaligned_store_in || is_ecall || is_ebreak;

  // Descending scan so the lowest pending line wins.
  always_comb begin
    irq_cause = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_pend[k]) irq_cause = CAUSE_W'(IRQ_CAUSE_BASE + k);
    end
  end

  always_comb begin
    trap_cause = '0;
    if (irq_req)                  trap_cause = irq_cause;
    else if (illegal_instr_in)    trap_cause = CAUSE_ILLEGAL;
    else if (misaligned_instr_in) trap_cause = CAUSE_MIS_INSTR;
    else if (is_ecall)            trap_cause = CAUSE_ECALL;
    else if (is_ebreak)           trap_cause = CAUSE_EBREAK;
    else if (misaligned_store_in) trap_cause = CAUSE_MIS_STORE;
    else if (misaligned_load_in)  trap_cause = CAUSE_MIS_LOAD;
  end

  always_comb begin
    state_d          = state_q;
    boot_cnt_d       = boot_cnt_q;
    cause_d          = cause_q;
    i_or_e_d         = i_or_e_q;
    pc_src_out       = 2'b00;
    flush_out        = 1'b0;
    instruct_inc_out = 1'b0;
    set_epc_out      = 1'b0;
    set_cause_out    = 1'b0;
    mie_clear_out    = 1'b0;
    mie_set_out      = 1'b0;
    trap_taken_out   = 1'b0;
    case (state_q)
      ST_RESET: begin
        pc_src_out = 2'b00;
        flush_out  = 1'b1;
        if (boot_cnt_q == '0) state_d = ST_OPERATING;
        else                  boot_cnt_d = boot_cnt_q - 1'b1;
      end
      ST_OPERATING: begin
        pc_src_out       = 2'b01;
        instruct_inc_out = 1'b1;
        if (trap_req) begin
          state_d  = ST_TRAP_TAKEN;
          cause_d  = trap_cause;
          i_or_e_d = irq_req;
        end else if (is_mret) begin
          state_d = ST_TRAP_RETURN;
        end
      end
      ST_TRAP_TAKEN: begin
        pc_src_out     = 2'b10;
        flush_out      = 1'b1;
        set_epc_out    = 1'b1;
        set_cause_out  = 1'b1;
        mie_clear_out  = 1'b1;
        trap_taken_out = 1'b1;
        state_d        = ST_OPERATING;
      end
      default: begin
        pc_src_out  = 2'b11;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
        state_d     = ST_OPERATING;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= ST_RESET;
      boot_cnt_q   <= CNT_W'(BOOT_CYCLES);
      cause_q      <= '0;
      i_or_e_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      cause_q      <= cause_d;
      i_or_e_q     <= i_or_e_d;
      misaligned_q <= misaligned_instr_in | misaligned_load_in | misaligned_store_in;
    end
  end

  assign cause_out                = cause_q;
  assign i_or_e_out               = i_or_e_q;
  assign misaligned_exception_out = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_machine_trap_controller.sv
`default_nettype none
// ============================================================================
// tb_machine_trap_controller : directed + random check against a cycle model
// Revision 1.0
// ============================================================================
module tb_machine_trap_controller;

  localparam int NUM_IRQ        = 3;
  localparam int CAUSE_W        = 5;
  localparam int IRQ_CAUSE_BASE = 16;
  localparam int BOOT_CYCLES    = 2;

  logic clk = 1'b0;
  logic rst_in, illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in;
  logic [4:0] opcode_6_to_2_in, rs1_adder_in, rs2_adder_in, rd_adder_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [NUM_IRQ-1:0] irq_in, irq_en_in;
  logic mie_in;
  logic [1:0] pc_src_out;
  logic flush_out, instruct_inc_out, set_epc_out, set_cause_out, mie_clear_out, mie_set_out;
  logic trap_taken_out, i_or_e_out, misaligned_exception_out;
  logic [CAUSE_W-1:0] cause_out;

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = RESET, 1 = OPERATING, 2 = TRAP_TAKEN, 3 = TRAP_RETURN
  int m_state = 0;
  int m_reset_cycles = 0;
  int m_cause = 0;
  int m_ie = 0;
  int m_mis = 0;

  always #5 clk = ~clk;

  machine_trap_controller #(
    .NUM_IRQ(NUM_IRQ), .CAUSE_W(CAUSE_W),
    .IRQ_CAUSE_BASE(IRQ_CAUSE_BASE), .BOOT_CYCLES(BOOT_CYCLES)
  ) u_dut (
    .clk_in(clk), .rst_in(rst_in),
    .illegal_instr_in(illegal_instr_in), .misaligned_instr_in(misaligned_instr_in),
    .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
    .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_adder_in(rs1_adder_in), .rs2_adder_in(rs2_adder_in), .rd_adder_in(rd_adder_in),
    .irq_in(irq_in), .irq_en_in(irq_en_in), .mie_in(mie_in),
    .pc_src_out(pc_src_out), .flush_out(flush_out), .instruct_inc_out(instruct_inc_out),
    .set_epc_out(set_epc_out), .set_cause_out(set_cause_out),
    .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .trap_taken_out(trap_taken_out), .i_or_e_out(i_or_e_out), .cause_out(cause_out),
    .misaligned_exception_out(misaligned_exception_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit sys_match(input int rs2, input int f7);
    return opcode_6_to_2_in == 5'b11100 && rs1_adder_in == 0 && rd_adder_in == 0 &&
           funct3_in == 0 && rs2_adder_in == rs2 && funct7_in == f7;
  endfunction

  // Priority list walk: first hit in the ordered list sets the cause.
  task automatic model_trap(output bit trap, output int code, output int is_irq);
    bit ex[6];
    int codes[6];
    trap = 0; code = 0; is_irq = 0;
    if (mie_in) begin
      for (int k = 0; k < NUM_IRQ; k++) begin
        if (!trap && irq_in[k] && irq_en_in[k]) begin
          trap = 1; code = IRQ_CAUSE_BASE + k; is_irq = 1;
        end
      end
    end
    ex    = '{illegal_instr_in, misaligned_instr_in, sys_match(0, 0), sys_match(1, 0),
              misaligned_store_in, misaligned_load_in};
    codes = '{2, 0, 11, 3, 6, 4};
    for (int i = 0; i < 6; i++) begin
      if (!trap && ex[i]) begin
        trap = 1; code = codes[i];
      end
    end
  endtask

  task automatic model_step();
    bit trap;
    int code, irq;
    if (!rst_in) begin
      m_state = 0; m_reset_cycles = 0; m_cause = 0; m_ie = 0; m_mis = 0;
    end else begin
      model_trap(trap, code, irq);
      m_mis = int'(misaligned_instr_in | misaligned_load_in | misaligned_store_in);
      case (m_state)
        0: if (m_reset_cycles == BOOT_CYCLES) m_state = 1; else m_reset_cycles++;
        1: if (trap) begin
             m_state = 2; m_cause = code; m_ie = irq;
           end else if (sys_match(2, 7'b0011000)) m_state = 3;
        default: m_state = 1;
      endcase
    end
  endtask

  task automatic check_all();
    check("pc_src",       pc_src_out,       m_state);
    check("flush",        flush_out,        int'(m_state != 1));
    check("instruct_inc", instruct_inc_out, int'(m_state == 1));
    check("set_epc",      set_epc_out,      int'(m_state == 2));
    check("set_cause",    set_cause_out,    int'(m_state == 2));
    check("mie_clear",    mie_clear_out,    int'(m_state == 2));
    check("trap_taken",   trap_taken_out,   int'(m_state == 2));
    check("mie_set",      mie_set_out,      int'(m_state == 3));
    check("cause",        cause_out,        m_cause);
    check("i_or_e",       i_or_e_out,       m_ie);
    check("misaligned",   misaligned_exception_out, m_mis);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    illegal_instr_in = 0; misaligned_instr_in = 0;
    misaligned_load_in = 0; misaligned_store_in = 0;
    opcode_6_to_2_in = 5'b01100; funct3_in = 0; funct7_in = 0;
    rs1_adder_in = 0; rs2_adder_in = 0; rd_adder_in = 0;
    irq_in = 0; irq_en_in = 0; mie_in = 0;
  endtask

  // kind: 0 none, 1 ecall, 2 ebreak, 3 mret
  task automatic set_instr(input int kind);
    opcode_6_to_2_in = (kind == 0) ? 5'b01100 : 5'b11100;
    funct3_in = 0; rs1_adder_in = 0; rd_adder_in = 0;
    rs2_adder_in = (kind == 3) ? 5'd2 : (kind == 2) ? 5'd1 : 5'd0;
    funct7_in    = (kind == 3) ? 7'b0011000 : 7'd0;
  endtask

  initial begin
    idle_inputs();
    rst_in = 0;
    repeat (3) tick();
    rst_in = 1;
    tick(); check("boot_pc_1", pc_src_out, 0);
    tick(); check("boot_pc_2", pc_src_out, 0);
    tick(); check("boot_done_inc", instruct_inc_out, 1);

    mie_in = 1; irq_en_in = 3'b111; irq_in = 3'b110;
    tick(); check("irq_cause", cause_out, 17); check("irq_ie", i_or_e_out, 1);
    idle_inputs();
    tick(); check("irq_back_op", pc_src_out, 1);

    mie_in = 0; irq_in = 3'b111; irq_en_in = 3'b111; set_instr(1);
    tick(); check("ecall_cause", cause_out, 11); check("ecall_ie", i_or_e_out, 0);
    idle_inputs();
    tick();

    illegal_instr_in = 1; misaligned_load_in = 1; set_instr(3);
    tick(); check("illegal_cause", cause_out, 2);
    idle_inputs();
    tick(); check("no_mret_after_trap", pc_src_out, 1);

    set_instr(3);
    tick(); check("mret_pc", pc_src_out, 3); check("mret_mie_set", mie_set_out, 1);
    idle_inputs();
    tick();

    set_instr(2);
    tick(); check("ebreak_tt", trap_taken_out, 1);
    idle_inputs(); rst_in = 0;
    tick(); check("rst_mid_cause", cause_out, 0); check("rst_mid_tt", trap_taken_out, 0);
    rst_in = 1;

    for (int n = 0; n < 3000; n++) begin
      int r;
      rst_in = ($urandom_range(0, 59) != 0);
      illegal_instr_in    = ($urandom_range(0, 11) == 0);
      misaligned_instr_in = ($urandom_range(0, 11) == 0);
      misaligned_load_in  = ($urandom_range(0, 11) == 0);
      misaligned_store_in = ($urandom_range(0, 11) == 0);
      mie_in    = $urandom_range(0, 1);
      irq_en_in = NUM_IRQ'($urandom);
      irq_in    = ($urandom_range(0, 3) == 0) ? NUM_IRQ'($urandom) : '0;
      r = $urandom_range(0, 9);
      if (r <= 3) set_instr(r);
      else if (r == 4) begin
        set_instr($urandom_range(1, 3));
        case ($urandom_range(0, 4))
          0: funct3_in    = 3'($urandom_range(1, 7));
          1: rs1_adder_in = 5'($urandom_range(1, 31));
          2: rd_adder_in  = 5'($urandom_range(1, 31));
          3: funct7_in    = funct7_in ^ 7'(1 << $urandom_range(0, 6));
          default: opcode_6_to_2_in = opcode_6_to_2_in ^ 5'(1 << $urandom_range(0, 4));
        endcase
      end else if (r == 5) set_instr(3);
      else begin
        opcode_6_to_2_in = 5'($urandom); funct3_in = 3'($urandom); funct7_in = 7'($urandom);
        rs1_adder_in = 5'($urandom); rs2_adder_in = 5'($urandom); rd_adder_in = 5'($urandom);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
